bkram_sd: RTL and testbench

BKRAM_SD -- requirements
Module: bkram_sd

---
 rtl/gb_pkg.sv | 31 +++
 rtl/bkram_sd.sv | 245 ++++++++++++++++++++++++
 tb/tb_bkram_sd.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gb_pkg.sv
// Shared definitions for the cartridge backup-RAM / SD save engine:
// controller states, MBC2 type codes and the header RAM-size decode.
package gb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2,
    ST_NEXT = 2'd3
  } bk_state_t;

  localparam logic [7:0] MBC2_TYPE_A = 8'h05;
  localparam logic [7:0] MBC2_TYPE_B = 8'h06;

  // Number of 512-byte sectors backing the cartridge RAM; MBC2 has 512x4 bits on-chip.
  function automatic logic [8:0] sector_count(input logic [7:0] ram_size,
                                              input logic [7:0] mbc_type);
    logic [8:0] n;
    case (ram_size)
      8'h00:   n = 9'd0;
      8'h01:   n = 9'd4;
      8'h02:   n = 9'd16;
      8'h03:   n = 9'd64;
      8'h04:   n = 9'd256;
      8'h05:   n = 9'd128;
      default: n = 9'd0;
    endcase
    return ((mbc_type == MBC2_TYPE_A) || (mbc_type == MBC2_TYPE_B)) ? 9'd1 : n;
  endfunction

endpackage

// File: rtl/bkram_sd.sv
// Moves cartridge backup RAM between the core and the SD save image, sector by sector.
// Optional build macro BKRAM_AUTOSAVE_EN: closing the OSD with autosave set requests a save.
module bkram_sd
  import gb_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic [7:0]        cart_ram_size,
  input  logic [7:0]        cart_mbc_type,
  input  logic              img_mounted,
  input  logic              img_readonly,
  input  logic [63:0]       img_size,
  input  logic              bk_save,
  input  logic              bk_dirty,
  input  logic              osd_status,
  input  logic              autosave,
  output logic [31:0]       sd_lba,
  output logic              sd_rd,
  output logic              sd_wr,
  input  logic              sd_ack,
  input  logic [7:0]        sd_buff_addr,
  input  logic [15:0]       sd_buff_dout,
  input  logic              sd_buff_wr,
  output logic [15:0]       sd_buff_din,
  output logic [ADDR_W-1:0] bk_addr,
  output logic [15:0]       bk_din,
  output logic              bk_we,
  input  logic [15:0]       bk_q,
  output logic              bk_loading,
  output logic              bk_pending,
  output logic              bk_busy
);

  bk_state_t         state;
  bk_state_t         state_next;
  logic              dir;
  logic              dir_next;
  logic              rd_next;
  logic              wr_next;
  logic [31:0]       lba_next;
  logic              we_next;
  logic [8:0]        n_sectors;
  logic [31:0]       last_lba;
  logic              last_sector;
  logic              save_trig;
  logic              save_req;
  logic              dirty_in_save;
  logic              img_valid;
  logic              img_ro;
  logic              ack_q;
  logic              ack_fall;
  logic              start_load;
  logic              start_save;
  logic              finish;
  logic [ADDR_W-1:0] wr_addr;

`ifdef BKRAM_AUTOSAVE_EN
  logic osd_q;

  // OSD state delayed by one cycle to spot the menu closing
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      osd_q <= 1'b0;
    end else begin
      osd_q <= osd_status;
    end
  end

  assign save_trig = bk_save | (osd_q & ~osd_status & autosave);
`else
  logic unused_cfg;
  assign unused_cfg = osd_status ^ autosave;
  assign save_trig  = bk_save;
`endif

  assign n_sectors   = sector_count(cart_ram_size, cart_mbc_type);
  assign last_lba    = {23'd0, n_sectors} - 32'd1;
  assign last_sector = (n_sectors == 9'd0) || (sd_lba >= last_lba);
  assign ack_fall    = ack_q & ~sd_ack;

  // A new mount always wins over a save requested in the same cycle
  assign start_load = (state == ST_IDLE) && img_mounted &&
                      (img_size != 64'd0) && (n_sectors != 9'd0);
  assign start_save = (state == ST_IDLE) && !start_load && save_req && bk_pending &&
                      (n_sectors != 9'd0) && img_valid && !img_ro;
  assign finish     = (state == ST_NEXT) && last_sector;

  assign bk_busy     = (state != ST_IDLE);
  assign sd_buff_din = bk_q;
  assign bk_addr     = ((state == ST_XFER) && dir) ? ADDR_W'({sd_lba, sd_buff_addr}) : wr_addr;

  // State register
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start_load || start_save) state_next = ST_REQ;
        else                          state_next = ST_IDLE;
      end
      ST_REQ: begin
        if (sd_ack) state_next = ST_XFER;
        else        state_next = ST_REQ;
      end
      ST_XFER: begin
        if (ack_fall) state_next = ST_NEXT;
        else          state_next = ST_XFER;
      end
      ST_NEXT: begin
        if (last_sector) state_next = ST_IDLE;
        else             state_next = ST_REQ;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Next values of the registered SD request, sector address and direction
  always_comb begin
    rd_next  = sd_rd;
    wr_next  = sd_wr;
    lba_next = sd_lba;
    dir_next = dir;
    we_next  = (state == ST_XFER) && !dir && sd_buff_wr;
    case (state)
      ST_IDLE: begin
        if (start_load) begin
          dir_next = 1'b0;
          lba_next = 32'd0;
          rd_next  = 1'b1;
          wr_next  = 1'b0;
        end else if (start_save) begin
          dir_next = 1'b1;
          lba_next = 32'd0;
          rd_next  = 1'b0;
          wr_next  = 1'b1;
        end else begin
          rd_next  = 1'b0;
          wr_next  = 1'b0;
        end
      end
      ST_REQ: begin
        if (sd_ack) begin
          rd_next = 1'b0;
          wr_next = 1'b0;
        end else begin
          rd_next = ~dir;
          wr_next = dir;
        end
      end
      ST_XFER: begin
        rd_next = 1'b0;
        wr_next = 1'b0;
      end
      ST_NEXT: begin
        if (last_sector) begin
          rd_next = 1'b0;
          wr_next = 1'b0;
        end else begin
          lba_next = sd_lba + 32'd1;
          rd_next  = ~dir;
          wr_next  = dir;
        end
      end
      default: begin
        rd_next = 1'b0;
        wr_next = 1'b0;
      end
    endcase
  end

  // Registered SD-side outputs
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sd_rd  <= 1'b0;
      sd_wr  <= 1'b0;
      sd_lba <= 32'd0;
      dir    <= 1'b0;
    end else begin
      sd_rd  <= rd_next;
      sd_wr  <= wr_next;
      sd_lba <= lba_next;
      dir    <= dir_next;
    end
  end

  // Status flags, save latch, image info and the RAM write port
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ack_q         <= 1'b0;
      img_valid     <= 1'b0;
      img_ro        <= 1'b0;
      save_req      <= 1'b0;
      dirty_in_save <= 1'b0;
      bk_loading    <= 1'b0;
      bk_pending    <= 1'b0;
      bk_we         <= 1'b0;
      bk_din        <= 16'd0;
      wr_addr       <= '0;
    end else begin
      ack_q <= sd_ack;
      bk_we <= we_next;
      if (img_mounted) begin
        img_valid <= (img_size != 64'd0);
        img_ro    <= img_readonly;
      end
      // The latch is consumed whenever IDLE does not start a load, serviced or not
      if (save_trig) begin
        save_req <= 1'b1;
      end else if ((state == ST_IDLE) && !start_load) begin
        save_req <= 1'b0;
      end
      if (start_load) begin
        bk_loading <= 1'b1;
      end else if (finish && !dir) begin
        bk_loading <= 1'b0;
      end
      // Writes landing during a save may have missed the image, so keep them pending
      if (start_save) begin
        dirty_in_save <= bk_dirty;
      end else if (bk_dirty && (state != ST_IDLE) && dir) begin
        dirty_in_save <= 1'b1;
      end
      if (finish && dir) begin
        bk_pending <= dirty_in_save | bk_dirty;
      end else if (bk_dirty && !bk_loading) begin
        bk_pending <= 1'b1;
      end
      if (we_next) begin
        bk_din  <= sd_buff_dout;
        wr_addr <= ADDR_W'({sd_lba[7:0], sd_buff_addr});
      end
    end
  end

endmodule

// File: tb/tb_bkram_sd.sv
// Directed bench for bkram_sd: HPS sector handshakes, backup-RAM model and
// hand-computed expectations for load, save, clean/read-only save, collision and reset.
module tb_bkram_sd;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [7:0]  cart_ram_size, cart_mbc_type;
  logic        img_mounted, img_readonly;
  logic [63:0] img_size;
  logic        bk_save, bk_dirty, osd_status, autosave;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr, sd_ack;
  logic [7:0]  sd_buff_addr;
  logic [15:0] sd_buff_dout;
  logic        sd_buff_wr;
  logic [15:0] sd_buff_din;
  logic [15:0] bk_addr, bk_din, bk_q;
  logic        bk_we, bk_loading, bk_pending, bk_busy;

  int errors = 0;
  int checks = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int we_cnt = 0;
  logic rd_q = 1'b0;
  logic wr_q = 1'b0;
  logic busy_seen;
  logic [15:0] mem [0:65535];
  logic [15:0] ram_q;

  always #5 clk_sys = ~clk_sys;

  bkram_sd #(.ADDR_W(16)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .cart_ram_size(cart_ram_size), .cart_mbc_type(cart_mbc_type),
    .img_mounted(img_mounted), .img_readonly(img_readonly), .img_size(img_size),
    .bk_save(bk_save), .bk_dirty(bk_dirty), .osd_status(osd_status), .autosave(autosave),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout), .sd_buff_wr(sd_buff_wr),
    .sd_buff_din(sd_buff_din), .bk_addr(bk_addr), .bk_din(bk_din), .bk_we(bk_we),
    .bk_q(bk_q), .bk_loading(bk_loading), .bk_pending(bk_pending), .bk_busy(bk_busy)
  );

  // Backup RAM with registered read, plus handshake and write-pulse counters
  always @(posedge clk_sys) begin
    if (bk_we) mem[bk_addr] <= bk_din;
    ram_q <= mem[bk_addr];
    rd_q  <= sd_rd;
    wr_q  <= sd_wr;
    if (sd_rd && !rd_q) rd_cnt <= rd_cnt + 1;
    if (sd_wr && !wr_q) wr_cnt <= wr_cnt + 1;
    if (bk_we) we_cnt <= we_cnt + 1;
  end
  assign bk_q = ram_q;

  initial begin
    #5000000;
    $display("FAIL watchdog: run still active, expected to finish");
    $fatal(1);
  end

  function automatic logic [15:0] pat(input logic [7:0] lba, input logic [7:0] a);
    return {lba, a} ^ 16'hA5C3;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic wait_req(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (sd_rd || sd_wr) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_sys);
    end
  endtask

  task automatic watch_idle(input int n);
    busy_seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick(1);
      if (bk_busy || sd_wr) busy_seen = 1'b1;
    end
  endtask

  // One HPS sector transfer; checks request, data and the post-sector state
  task automatic serve_sector(input logic save, input int lba, input logic last,
                              input logic dirty_mid);
    logic ok;
    wait_req(ok);
    check("req_seen", ok, 1'b1);
    if (!ok) return;
    check("req_rd", sd_rd, !save);
    check("req_wr", sd_wr, save);
    check("req_lba", sd_lba, lba);
    sd_ack = 1'b1;
    tick(1);
    check("req_drop", {sd_rd, sd_wr}, 2'b00);
    bk_dirty = dirty_mid;
    if (!save) begin
      for (int a = 0; a < 256; a++) begin
        sd_buff_addr = 8'(a);
        sd_buff_dout = pat(8'(lba), 8'(a));
        sd_buff_wr   = 1'b1;
        tick(1);
        bk_dirty = 1'b0;
      end
      sd_buff_wr = 1'b0;
    end else begin
      sd_buff_addr = 8'd0;
      for (int a = 0; a < 256; a++) begin
        tick(1);
        bk_dirty = 1'b0;
        check("save_din", sd_buff_din, pat(8'(lba), 8'(a)));
        sd_buff_addr = 8'(a + 1);
      end
    end
    sd_ack = 1'b0;
    tick(1);
    check("next_busy", bk_busy, 1'b1);
    tick(1);
    check("end_busy", bk_busy, !last);
  endtask

  initial begin
    logic ok;
    reset = 1'b1; cart_ram_size = 8'h00; cart_mbc_type = 8'h00;
    img_mounted = 1'b0; img_readonly = 1'b0; img_size = 64'd0;
    bk_save = 1'b0; bk_dirty = 1'b0; osd_status = 1'b0; autosave = 1'b0;
    sd_ack = 1'b0; sd_buff_addr = 8'd0; sd_buff_dout = 16'd0; sd_buff_wr = 1'b0;
    tick(3);
    check("rst_rdwr", {sd_rd, sd_wr, bk_we}, 3'b000);
    check("rst_lba", sd_lba, 32'd0);
    check("rst_flags", {bk_loading, bk_pending, bk_busy}, 3'b000);
    reset = 1'b0;
    tick(1);

    // Load: 16 sectors of 256 words
    cart_ram_size = 8'h02; img_size = 64'd8192; img_mounted = 1'b1;
    tick(1);
    img_mounted = 1'b0;
    check("load_start", {bk_loading, bk_busy}, 2'b11);
    for (int l = 0; l < 16; l++) serve_sector(1'b0, l, l == 15, 1'b0);
    check("load_rd_cnt", rd_cnt, 16);
    check("load_we_cnt", we_cnt, 4096);
    check("load_wr_cnt", wr_cnt, 0);
    check("load_done", bk_loading, 1'b0);
    check("mem_0000", mem[16'h0000], 16'hA5C3);
    check("mem_0a37", mem[16'h0A37], 16'hAFF4);
    check("mem_0fff", mem[16'h0FFF], 16'hAA3C);

    // Dirty save: 4 sectors read back from RAM
    bk_dirty = 1'b1;
    tick(1);
    bk_dirty = 1'b0;
    check("dirty_pend", bk_pending, 1'b1);
    cart_ram_size = 8'h01; bk_save = 1'b1;
    tick(1);
    bk_save = 1'b0;
    for (int l = 0; l < 4; l++) serve_sector(1'b1, l, l == 3, 1'b0);
    check("save_wr_cnt", wr_cnt, 4);
    check("save_pend_clr", bk_pending, 1'b0);

    // Clean save does nothing
    bk_save = 1'b1;
    tick(1);
    bk_save = 1'b0;
    watch_idle(10);
    check("clean_busy", busy_seen, 1'b0);
    check("clean_wr_cnt", wr_cnt, 4);

    // Read-only image (no RAM size at mount, so no load)
    cart_ram_size = 8'h00; img_readonly = 1'b1; img_mounted = 1'b1;
    tick(1);
    img_mounted = 1'b0; cart_ram_size = 8'h01; bk_dirty = 1'b1;
    tick(1);
    bk_dirty = 1'b0; bk_save = 1'b1;
    tick(1);
    bk_save = 1'b0;
    watch_idle(10);
    check("ro_busy", busy_seen, 1'b0);
    check("ro_wr_cnt", wr_cnt, 4);
    check("ro_rd_cnt", rd_cnt, 16);
    check("ro_pend", bk_pending, 1'b1);

    // Collision: load first, then save; a write during the save stays pending
    img_readonly = 1'b0; img_size = 64'd2048; img_mounted = 1'b1; bk_save = 1'b1;
    tick(1);
    img_mounted = 1'b0; bk_save = 1'b0;
    for (int l = 0; l < 4; l++) serve_sector(1'b0, l, l == 3, 1'b0);
    for (int l = 0; l < 4; l++) serve_sector(1'b1, l, l == 3, l == 0);
    check("coll_rd_cnt", rd_cnt, 20);
    check("coll_wr_cnt", wr_cnt, 8);
    check("coll_repend", bk_pending, 1'b1);

    // MBC2 forces a single sector
    cart_ram_size = 8'h00; cart_mbc_type = 8'h05; img_mounted = 1'b1;
    tick(1);
    img_mounted = 1'b0;
    serve_sector(1'b0, 0, 1'b1, 1'b0);
    check("mbc2_rd_cnt", rd_cnt, 21);

    // Reset in the middle of sector 3
    cart_mbc_type = 8'h00; cart_ram_size = 8'h03; img_mounted = 1'b1;
    tick(1);
    img_mounted = 1'b0;
    for (int l = 0; l < 3; l++) serve_sector(1'b0, l, 1'b0, 1'b0);
    wait_req(ok);
    check("mid_req", ok, 1'b1);
    check("mid_lba", sd_lba, 32'd3);
    sd_ack = 1'b1;
    tick(1);
    for (int a = 0; a < 5; a++) begin
      sd_buff_addr = 8'(a); sd_buff_dout = 16'h1234; sd_buff_wr = 1'b1;
      tick(1);
    end
    reset = 1'b1;
    tick(1);
    check("mid_rst_rd", {sd_rd, bk_we}, 2'b00);
    check("mid_rst_busy", bk_busy, 1'b0);
    check("mid_rst_flags", {bk_loading, bk_pending}, 2'b00);
    check("mid_rst_lba", sd_lba, 32'd0);
    reset = 1'b0; sd_ack = 1'b0; sd_buff_wr = 1'b0;
    tick(3);
    check("mid_no_resume", {bk_busy, sd_rd}, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
